riscv_pipe_ctrl: RTL
====================

// Module: riscv_pipe_ctrl
// PURPOSE
//  Central stall/flush sequencer for the 5-stage pipeline registers (PC, IF/ID, ID/EX, EX/MEM, MEM/WB).
//  Combines three hazard sources into per-stage stall/flush controls:
//   - load-use hazard, detected in ID against EX
//   - taken branch, resolved in MEM
//   - multi-cycle data-memory wait, via a req/ready handshake
//  Tracks memory waits with an FSM and timeout, and keeps saturating stall/flush statistics.
// PARAMETERS
//  WAIT_TIMEOUT  64  max consecutive dmem wait cycles before mem_err (>=2)
//  CNT_W         32  width of statistic counters
// PORTS
//  clk              in   1      rising-edge clock
//  rst_n            in   1      asynchronous, active-low reset
//  ex_MemtoReg      in   1      ID/EX holds a load
//  ex_rd_idx        in   5      ID/EX destination register
//  id_rs1_idx       in   5      IF/ID source 1 index
//  id_rs2_idx       in   5      IF/ID source 2 index
//  id_use_rs1       in   1      IF/ID instruction reads rs1
//  id_use_rs2       in   1      IF/ID instruction reads rs2
//  mem_branch_taken in   1      EX/MEM branch/jump resolved taken
//  mem_access       in   1      EX/MEM holds a load or store (MemtoReg|MemWr)
//  dmem_ready       in   1      data memory completes the access this cycle
//  pc_stall         out  1      hold PC
//  pc_redirect      out  1      PC takes branch target
//  stall_if_id      out  1      IF/ID stall
//  flush_if_id      out  1      IF/ID flush
//  stall_id_ex      out  1      ID/EX stall
//  flush_id_ex      out  1      ID/EX flush
//  stall_ex_mem     out  1      EX/MEM stall
//  flush_ex_mem     out  1      EX/MEM flush
//  flush_mem_wb     out  1      MEM/WB bubble insert
//  mem_err          out  1      sticky dmem timeout flag
//  stall_cnt        out  CNT_W  cycles with pc_stall=1, saturating
//  flush_cnt        out  CNT_W  branch redirects, saturating
// BEHAVIOUR
//  Reset (rst_n=0, async):
//   - state=RUN, wait_cnt=0, mem_err=0, stall_cnt=0, flush_cnt=0.
//   - All stall/flush/redirect outputs are forced 0 while rst_n=0.
//  Control outputs are combinational from state and inputs; stage registers act at the next edge.
//  Hazard terms:
//   - mw = mem_access & ~dmem_ready
//   - lu = ex_MemtoReg & ex_rd_idx!=0 & ((id_use_rs1 & id_rs1_idx==ex_rd_idx) | (id_use_rs2 & id_rs2_idx==ex_rd_idx))
//  Priority (exactly one applies per cycle): ERR > mw > branch > lu > none.
//   - ERR state: pc_stall, stall_if_id, stall_id_ex, stall_ex_mem = 1; flush_mem_wb = 1; all others 0.
//   - mw: the same stall set as ERR, plus flush_mem_wb=1; the pending branch/load-use action is deferred.
//   - branch (mw=0): pc_redirect, flush_if_id, flush_id_ex, flush_ex_mem = 1; no stalls; lu is ignored.
//   - lu only: pc_stall, stall_if_id, flush_id_ex = 1 (one bubble).
//   - Stall and flush are never asserted together on the same pipeline register.
//  FSM (state encodings in riscv_define.v):
//   - RUN: mw -> MEM_WAIT, wait_cnt=1; else stay.
//   - MEM_WAIT:
//     - dmem_ready=1 -> RUN, wait_cnt=0; the access completes and MEM/WB loads normally that edge.
//     - else if wait_cnt==WAIT_TIMEOUT-1 -> ERR, mem_err=1.
//     - else wait_cnt+1.
//     - mem_access dropping to 0 in MEM_WAIT (protocol error) -> RUN.
//   - ERR: held until reset; no exit on any input.
//  Counters:
//   - stall_cnt increments every cycle pc_stall=1.
//   - flush_cnt increments every cycle pc_redirect=1.
//   - Both saturate at all-ones and never wrap.
//  Reset asserted mid-wait returns to RUN at once; the access in flight is abandoned.
// STRUCTURE
//  riscv_define.v: FSM state encodings (RUN/MEM_WAIT/ERR, 2 bits), PC_STALL_*/redirect mnemonics.
//  Sub-module riscv_hazard_detect: purely combinational lu comparator, instantiated once.
//  Top level: FSM, wait counter, priority mux, statistic counters.
// TESTING
//  1. lw x5 in ID/EX, add x6,x5,x1 in IF/ID -> 1 cycle {pc_stall,stall_if_id,flush_id_ex}=1, stall_cnt=1.
//  2. Load with rd=x0 against a reader of x0 -> no stall.
//  3. mem_access=1, dmem_ready low 3 cycles -> 3 cycles full stall + flush_mem_wb, then RUN; stall_cnt=3.
//  4. Branch taken with lu true in the same cycle -> pc_redirect + 3 flushes, no stall; flush_cnt=1.
//  5. dmem_ready held low with WAIT_TIMEOUT=4 -> ERR after 4 wait cycles, mem_err sticky until rst_n pulse.
//  6. rst_n low mid MEM_WAIT -> outputs 0 immediately; counters 0; stall_cnt preloaded to max stays saturated.

Source files
------------

// File: rtl/riscv_pipe_ctrl_pkg.sv
// Shared types for the pipeline stall/flush sequencer: FSM states and the
// per-stage control bundle with its canned hazard responses.
package riscv_pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        StRun     = 2'b00,
        StMemWait = 2'b01,
        StErr     = 2'b10
    } pipe_state_e;

    typedef struct packed {
        logic pc_stall;
        logic pc_redirect;
        logic stall_if_id;
        logic flush_if_id;
        logic stall_id_ex;
        logic flush_id_ex;
        logic stall_ex_mem;
        logic flush_ex_mem;
        logic flush_mem_wb;
    } pipe_ctrl_t;

    // Freeze PC..EX/MEM and bubble MEM/WB; shared by dmem wait and the error trap.
    localparam pipe_ctrl_t CtrlMemStall = pipe_ctrl_t'(9'b1_0_1_0_1_0_1_0_1);
    localparam pipe_ctrl_t CtrlBranch   = pipe_ctrl_t'(9'b0_1_0_1_0_1_0_1_0);
    localparam pipe_ctrl_t CtrlLoadUse  = pipe_ctrl_t'(9'b1_0_1_0_0_1_0_0_0);
    localparam pipe_ctrl_t CtrlNone     = pipe_ctrl_t'(9'b0);

endpackage

// File: rtl/riscv_pipe_ctrl_hazard_detect.sv
// Load-use comparator: the load in ID/EX writes a register the IF/ID
// instruction reads. Writes to x0 never create a dependency.
module riscv_pipe_ctrl_hazard_detect (
    input  logic       ex_mem_to_reg,
    input  logic [4:0] ex_rd_idx,
    input  logic [4:0] id_rs1_idx,
    input  logic [4:0] id_rs2_idx,
    input  logic       id_use_rs1,
    input  logic       id_use_rs2,
    output logic       load_use
);

    logic rs1_hit;
    logic rs2_hit;

    always_comb begin
        rs1_hit  = id_use_rs1 && (id_rs1_idx == ex_rd_idx);
        rs2_hit  = id_use_rs2 && (id_rs2_idx == ex_rd_idx);
        load_use = ex_mem_to_reg && (ex_rd_idx != 5'd0) && (rs1_hit || rs2_hit);
    end

endmodule

// File: rtl/riscv_pipe_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline: prioritises dmem wait,
// taken branch and load-use hazards, traps dmem timeouts, keeps saturating stats.
module riscv_pipe_ctrl
    import riscv_pipe_ctrl_pkg::*;
#(
    parameter int unsigned WAIT_TIMEOUT = 64,
    parameter int unsigned CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ex_MemtoReg,
    input  logic [4:0]       ex_rd_idx,
    input  logic [4:0]       id_rs1_idx,
    input  logic [4:0]       id_rs2_idx,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic             mem_branch_taken,
    input  logic             mem_access,
    input  logic             dmem_ready,
    output logic             pc_stall,
    output logic             pc_redirect,
    output logic             stall_if_id,
    output logic             flush_if_id,
    output logic             stall_id_ex,
    output logic             flush_id_ex,
    output logic             stall_ex_mem,
    output logic             flush_ex_mem,
    output logic             flush_mem_wb,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int unsigned WaitW = (WAIT_TIMEOUT > 2) ? $clog2(WAIT_TIMEOUT) : 1;
    localparam logic [WaitW-1:0] WaitLast = WaitW'(WAIT_TIMEOUT - 1);

    pipe_state_e      state_q, state_d;
    logic [WaitW-1:0] wait_cnt_q, wait_cnt_d;
    logic             mem_err_q, mem_err_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic             load_use;
    logic             mem_wait;
    pipe_ctrl_t       ctrl;

    riscv_pipe_ctrl_hazard_detect u_hazard_detect (
        .ex_mem_to_reg (ex_MemtoReg),
        .ex_rd_idx     (ex_rd_idx),
        .id_rs1_idx    (id_rs1_idx),
        .id_rs2_idx    (id_rs2_idx),
        .id_use_rs1    (id_use_rs1),
        .id_use_rs2    (id_use_rs2),
        .load_use      (load_use)
    );

    assign mem_wait = mem_access && !dmem_ready;

    // Priority mux; reset gating keeps stage registers quiet during rst_n=0.
    always_comb begin
        ctrl = CtrlNone;
        if (!rst_n) begin
            ctrl = CtrlNone;
        end else if (state_q == StErr || mem_wait) begin
            ctrl = CtrlMemStall;
        end else if (mem_branch_taken) begin
            ctrl = CtrlBranch;
        end else if (load_use) begin
            ctrl = CtrlLoadUse;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        mem_err_d  = mem_err_q;
        case (state_q)
            StRun: begin
                if (mem_wait) begin
                    state_d    = StMemWait;
                    wait_cnt_d = WaitW'(1);
                end
            end
            StMemWait: begin
                // Ready completes the access; a dropped request abandons it.
                if (!mem_access || dmem_ready) begin
                    state_d    = StRun;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == WaitLast) begin
                    state_d   = StErr;
                    mem_err_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + WaitW'(1);
                end
            end
            StErr: begin
                state_d = StErr;
            end
            default: begin
                state_d    = StRun;
                wait_cnt_d = '0;
            end
        endcase

        stall_cnt_d = stall_cnt_q;
        if (ctrl.pc_stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        flush_cnt_d = flush_cnt_q;
        if (ctrl.pc_redirect && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StRun;
            wait_cnt_q  <= '0;
            mem_err_q   <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            mem_err_q   <= mem_err_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign pc_stall     = ctrl.pc_stall;
    assign pc_redirect  = ctrl.pc_redirect;
    assign stall_if_id  = ctrl.stall_if_id;
    assign flush_if_id  = ctrl.flush_if_id;
    assign stall_id_ex  = ctrl.stall_id_ex;
    assign flush_id_ex  = ctrl.flush_id_ex;
    assign stall_ex_mem = ctrl.stall_ex_mem;
    assign flush_ex_mem = ctrl.flush_ex_mem;
    assign flush_mem_wb = ctrl.flush_mem_wb;
    assign mem_err      = mem_err_q;
    assign stall_cnt    = stall_cnt_q;
    assign flush_cnt    = flush_cnt_q;

endmodule
